// File: rtl/reg_file_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_stack : general register file with mov/incr/decr and link stack |
// | Optional macro REG_BYPASS_EN forwards same-cycle writes to read ports.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reg_file_stack #(
  parameter int DW     = 8,
  parameter int NREG   = 16,
  parameter int AW     = 10,
  parameter int SDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en_i,
  input  logic [$clog2(NREG)-1:0] ld_sel_i,
  input  logic [DW-1:0]           ld_data_i,
  input  logic [1:0]              op_i,
  input  logic [$clog2(NREG)-1:0] src_sel_i,
  input  logic [$clog2(NREG)-1:0] dst_sel_i,
  input  logic [2:0]              step_i,
  input  logic [$clog2(NREG)-1:0] rd_sel_a_i,
  input  logic [$clog2(NREG)-1:0] rd_sel_b_i,
  output logic [DW-1:0]           rd_data_a_o,
  output logic [DW-1:0]           rd_data_b_o,
  output logic                    src_zero_o,
  input  logic                    call_i,
  input  logic                    ret_i,
  input  logic [AW-1:0]           npc_i,
  output logic [AW-1:0]           link_addr_o,
  output logic                    stk_empty_o,
  output logic                    stk_full_o,
  output logic                    stk_err_o
);
  localparam int PW = $clog2(SDEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MOV  = 2'd1;
  localparam logic [1:0] OP_INCR = 2'd2;
  localparam logic [1:0] OP_DECR = 2'd3;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] src_val;
  logic [DW-1:0] amt;
  logic [DW-1:0] op_val;
  logic          mov_clr;

  assign src_val = regs_q[src_sel_i];
  assign amt     = DW'({1'b0, step_i}) + DW'(1);
  assign mov_clr = (op_i == OP_MOV) && (src_sel_i == dst_sel_i);

  always_comb begin
    op_val = src_val;
    case (op_i)
      OP_MOV:  op_val = mov_clr ? '0 : src_val;
      OP_INCR: op_val = src_val + amt;
      OP_DECR: op_val = src_val - amt;
      default: op_val = src_val;
    endcase
  end

  // The load is applied last so it overrides an op aimed at the same register.
  always_comb begin
    regs_d = regs_q;
    if (op_i != OP_NONE) regs_d[dst_sel_i] = op_val;
    if (ld_en_i)         regs_d[ld_sel_i]  = ld_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REG_BYPASS_EN
  assign rd_data_a_o = regs_d[rd_sel_a_i];
  assign rd_data_b_o = regs_d[rd_sel_b_i];
  assign src_zero_o  = mov_clr || (regs_d[src_sel_i] == '0);
`else
  assign rd_data_a_o = regs_q[rd_sel_a_i];
  assign rd_data_b_o = regs_q[rd_sel_b_i];
  assign src_zero_o  = mov_clr || (src_val == '0);
`endif

  logic [AW-1:0] stk_q [SDEPTH];
  logic [AW-1:0] stk_d [SDEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          empty, full;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] push_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(SDEPTH));
  assign push_idx = cnt_q[PW-1:0];
  assign top_idx  = cnt_q[PW-1:0] - PW'(1);

  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case ({call_i, ret_i})
      2'b10: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          stk_d[push_idx] = npc_i;
          cnt_d           = cnt_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) err_d = 1'b1;
        else       cnt_d = cnt_q - CW'(1);
      end
      2'b11: begin
        if (empty) begin
          stk_d[push_idx] = npc_i;
          cnt_d           = cnt_q + CW'(1);
        end else begin
          stk_d[top_idx] = npc_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign link_addr_o = empty ? '0 : stk_q[top_idx];
  assign stk_empty_o = empty;
  assign stk_full_o  = full;
  assign stk_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_stack.sv
`default_nettype none
// Testbench for reg_file_stack: directed vector table, reset corner case,
// and randomized cycles checked against a queue-based reference model.
module tb_reg_file_stack;
`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en_i;
  logic [3:0] ld_sel_i;
  logic [7:0] ld_data_i;
  logic [1:0] op_i;
  logic [3:0] src_sel_i, dst_sel_i;
  logic [2:0] step_i;
  logic [3:0] rd_sel_a_i, rd_sel_b_i;
  logic [7:0] rd_data_a_o, rd_data_b_o;
  logic       src_zero_o;
  logic       call_i, ret_i;
  logic [9:0] npc_i;
  logic [9:0] link_addr_o;
  logic       stk_empty_o, stk_full_o, stk_err_o;

  reg_file_stack dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en_i(ld_en_i), .ld_sel_i(ld_sel_i), .ld_data_i(ld_data_i),
    .op_i(op_i), .src_sel_i(src_sel_i), .dst_sel_i(dst_sel_i), .step_i(step_i),
    .rd_sel_a_i(rd_sel_a_i), .rd_sel_b_i(rd_sel_b_i),
    .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o), .src_zero_o(src_zero_o),
    .call_i(call_i), .ret_i(ret_i), .npc_i(npc_i),
    .link_addr_o(link_addr_o), .stk_empty_o(stk_empty_o),
    .stk_full_o(stk_full_o), .stk_err_o(stk_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld_en, ld_sel, ld_data, op, src, dst, stp, rda, rdb, call, ret, npc;
    int e_rd, e_sz, e_link, e_emp, e_full, e_err;  // -1 = not checked
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_reg [16];
  int m_stk [$];
  int m_err;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_stk.delete();
    m_err = 0;
  endtask

  function automatic vec_t V(int ld_en, int ld_sel, int ld_data, int op, int src, int dst,
                             int stp, int rda, int call, int ret, int npc,
                             int e_rd, int e_sz, int e_link, int e_emp, int e_full, int e_err);
    vec_t v;
    v.ld_en = ld_en; v.ld_sel = ld_sel; v.ld_data = ld_data; v.op = op;
    v.src = src; v.dst = dst; v.stp = stp; v.rda = rda; v.rdb = rda;
    v.call = call; v.ret = ret; v.npc = npc;
    v.e_rd = e_rd; v.e_sz = e_sz; v.e_link = e_link;
    v.e_emp = e_emp; v.e_full = e_full; v.e_err = e_err;
    return v;
  endfunction

  // One clock cycle: drive at posedge+1, check mid-cycle, advance model after the edge.
  task automatic cyc(input vec_t v, input bit use_model, input string tag);
    int nxt [16];
    int val, cur_src, sz, top;
    ld_en_i = v.ld_en[0]; ld_sel_i = 4'(v.ld_sel); ld_data_i = 8'(v.ld_data);
    op_i = 2'(v.op); src_sel_i = 4'(v.src); dst_sel_i = 4'(v.dst); step_i = 3'(v.stp);
    rd_sel_a_i = 4'(v.rda); rd_sel_b_i = 4'(v.rdb);
    call_i = v.call[0]; ret_i = v.ret[0]; npc_i = 10'(v.npc);
    #4;
    nxt = m_reg;
    cur_src = m_reg[v.src];
    case (v.op)
      1: val = (v.src == v.dst) ? 0 : cur_src;
      2: val = (cur_src + v.stp + 1) & 255;
      3: val = (cur_src - v.stp - 1) & 255;
      default: val = cur_src;
    endcase
    if (v.op != 0) nxt[v.dst] = val;
    if (v.ld_en != 0) nxt[v.ld_sel] = v.ld_data;
    if (v.op == 1 && v.src == v.dst) sz = 1;
    else sz = ((BYP ? nxt[v.src] : m_reg[v.src]) == 0) ? 1 : 0;
    top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
    if (use_model) begin
      chk({tag, " rd_a"}, rd_data_a_o, BYP ? nxt[v.rda] : m_reg[v.rda]);
      chk({tag, " rd_b"}, rd_data_b_o, BYP ? nxt[v.rdb] : m_reg[v.rdb]);
      chk({tag, " src_zero"}, src_zero_o, sz);
      chk({tag, " link"}, link_addr_o, top);
      chk({tag, " empty"}, stk_empty_o, (m_stk.size() == 0) ? 1 : 0);
      chk({tag, " full"}, stk_full_o, (m_stk.size() == 4) ? 1 : 0);
      chk({tag, " err"}, stk_err_o, m_err);
    end else begin
      if (v.e_rd >= 0) begin
        chk({tag, " rd_a"}, rd_data_a_o, v.e_rd);
        chk({tag, " rd_b"}, rd_data_b_o, v.e_rd);
      end
      if (v.e_sz >= 0)   chk({tag, " src_zero"}, src_zero_o, v.e_sz);
      if (v.e_link >= 0) chk({tag, " link"}, link_addr_o, v.e_link);
      if (v.e_emp >= 0)  chk({tag, " empty"}, stk_empty_o, v.e_emp);
      if (v.e_full >= 0) chk({tag, " full"}, stk_full_o, v.e_full);
      if (v.e_err >= 0)  chk({tag, " err"}, stk_err_o, v.e_err);
    end
    @(posedge clk); #1;
    m_reg = nxt;
    if (v.call != 0 && v.ret != 0) begin
      if (m_stk.size() == 0) m_stk.push_back(v.npc);
      else m_stk[m_stk.size()-1] = v.npc;
    end else if (v.call != 0) begin
      if (m_stk.size() == 4) m_err = 1;
      else m_stk.push_back(v.npc);
    end else if (v.ret != 0) begin
      if (m_stk.size() == 0) m_err = 1;
      else void'(m_stk.pop_back());
    end
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    ld_en_i = 0; ld_sel_i = 0; ld_data_i = 0; op_i = 0; src_sel_i = 0; dst_sel_i = 0;
    step_i = 0; rd_sel_a_i = 3; rd_sel_b_i = 9; call_i = 0; ret_i = 0; npc_i = 0;
    model_reset();
    #3;
    chk("reset rd_a", rd_data_a_o, 0);
    chk("reset rd_b", rd_data_b_o, 0);
    chk("reset link", link_addr_o, 0);
    chk("reset empty", stk_empty_o, 1);
    chk("reset full", stk_full_o, 0);
    chk("reset err", stk_err_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //           ld ls dat   op s  d  st ra cl rt npc    rd   sz lnk  emp fl er
    tbl.push_back(V(1, 3, 'h7F, 0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    2, 3, 3, 0, 4, 0, 0, 0,     0,   0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 3, 0, 0, 3, 0, 0, 0,     'h80,0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    2, 3, 3, 7, 4, 0, 0, 0,     0,   0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 3, 0, 0, 3, 0, 0, 0,     'h88,0, 0,   1, 0, 0));
    tbl.push_back(V(1, 5, 3,    0, 3, 0, 0, 3, 0, 0, 0,     'h88,0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    3, 5, 5, 4, 3, 0, 0, 0,     'h88,0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     'hFE,0, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    1, 5, 5, 0, 3, 0, 0, 0,     'h88,1, 0,   1, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     0,   1, 0,   1, 0, 0));
    // Link stack: five calls, four rets
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h100, 0,   1, 0,     1, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h101, 0,   1, 'h100, 0, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h102, 0,   1, 'h101, 0, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h103, 0,   1, 'h102, 0, 0, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h104, 0,   1, 'h103, 0, 1, 0));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h103, 0, 1, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h102, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h101, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h100, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     0,   1, 0,     1, 0, 1));
    // Simultaneous call+ret at occupancy 2, then on an empty stack
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h050, 0,   1, 0,     1, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 0, 'h060, 0,   1, 'h050, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 1, 'h2AA, 0,   1, 'h060, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     0,   1, 'h2AA, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h2AA, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h050, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 1, 1, 'h123, 0,   1, 0,     1, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     0,   1, 'h123, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 1, 0,     0,   1, 'h123, 0, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 5, 0, 0, 5, 0, 0, 0,     0,   1, 0,     1, 0, 1));
    // Load vs op collisions
    tbl.push_back(V(1, 7, 'h22, 0, 3, 0, 0, 0, 0, 0, 0,     0,   0, 0,   1, 0, 1));
    tbl.push_back(V(1, 7, 'h11, 1, 3, 7, 0, 7, 0, 0, 0,     BYP ? 'h11 : 'h22, 0, 0, 1, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 3, 0, 0, 7, 0, 0, 0,     'h11,0, 0,   1, 0, 1));
    tbl.push_back(V(1, 8, 'h5A, 2, 3, 9, 1, 3, 0, 0, 0,     'h88,0, 0,   1, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 3, 0, 0, 8, 0, 0, 0,     'h5A,0, 0,   1, 0, 1));
    tbl.push_back(V(0, 0, 0,    0, 3, 0, 0, 9, 0, 0, 0,     'h8A,0, 0,   1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset between edges while a push is pending
    call_i = 1; ret_i = 0; npc_i = 10'h3FF; op_i = 0; ld_en_i = 0;
    rd_sel_a_i = 9; rd_sel_b_i = 8;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst rd_a", rd_data_a_o, 0);
    chk("midrst rd_b", rd_data_b_o, 0);
    chk("midrst link", link_addr_o, 0);
    chk("midrst empty", stk_empty_o, 1);
    chk("midrst err", stk_err_o, 0);
    call_i = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("postrst link", link_addr_o, 0);
    chk("postrst empty", stk_empty_o, 1);
    chk("postrst err", stk_err_o, 0);

    // Randomized cycles against the reference model
    for (int i = 0; i < 400; i++) begin
      rv = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
      rv.ld_en   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv.ld_sel  = $urandom_range(0, 15);
      rv.ld_data = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
      rv.op      = $urandom_range(0, 3);
      rv.src     = $urandom_range(0, 15);
      rv.dst     = ($urandom_range(0, 3) == 0) ? rv.src : $urandom_range(0, 15);
      rv.stp     = $urandom_range(0, 7);
      rv.rda     = $urandom_range(0, 15);
      rv.rdb     = ($urandom_range(0, 1) == 0) ? rv.dst : $urandom_range(0, 15);
      rv.call    = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rv.ret     = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rv.npc     = $urandom_range(0, 1023);
      cyc(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_file_stack.md
REG_FILE_STACK -- requirements
Module: reg_file_stack

Interface
REQ-001 Parameter DW, default 8, data width of each general register.
REQ-002 Parameter NREG, default 16, number of general registers; power of two, at least 4.
REQ-003 Parameter AW, default 10, program-address width of link entries.
REQ-004 Parameter SDEPTH, default 4, link-stack depth; power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ld_en  input  1  load-write request from the memory path.
REQ-008 ld_sel  input  log2(NREG)  load destination register.
REQ-009 ld_data  input  DW  load data.
REQ-010 op  input  2  register operation: 0 none, 1 mov, 2 incr, 3 decr.
REQ-011 src_sel, dst_sel  input  log2(NREG) each  operation source and destination registers.
REQ-012 step  input  3  incr/decr amount minus one (range 1..8).
REQ-013 rd_sel_a, rd_sel_b  input  log2(NREG) each  read-port selects.
REQ-014 rd_data_a, rd_data_b  output  DW each  read-port data.
REQ-015 src_zero  output  1  high when the selected source operand equals zero.
REQ-016 call, ret  input  1 each  push and pop link-stack requests.
REQ-017 npc  input  AW  return address pushed on call.
REQ-018 link_addr  output  AW  current top-of-stack entry; 0 when empty.
REQ-019 stk_empty, stk_full  output  1 each  link-stack occupancy flags.
REQ-020 stk_err  output  1  sticky overflow/underflow error.

Function
REQ-021 Read ports SHALL be combinational from register state, with zero cycles of latency.
REQ-022 mov SHALL write reg[src_sel] to reg[dst_sel] at the next edge; when src_sel equals dst_sel, mov SHALL write zero to the destination (clear idiom).
REQ-023 incr SHALL write reg[src_sel] + (step+1) and decr SHALL write reg[src_sel] - (step+1), both modulo 2^DW.
REQ-024 src_zero SHALL reflect reg[src_sel] == 0 before the operation; for a mov with src_sel equal to dst_sel it SHALL read 1.
REQ-025 When ld_en and an op are active on the same cycle, the load SHALL win if both target the same register; otherwise both writes SHALL commit on the same edge.
REQ-026 On call alone while not full, npc SHALL be pushed, occupancy SHALL increment, and link_addr SHALL equal npc on the following cycle.
REQ-027 On ret alone while not empty, the top SHALL be popped and link_addr SHALL show the previous entry, or 0 when the stack becomes empty.
REQ-028 On call and ret together, the top entry SHALL be replaced by npc with occupancy unchanged; if the stack is empty, this SHALL act as a push.
REQ-029 On call while full, the stack SHALL be left unchanged and stk_err SHALL set.
REQ-030 On ret while empty, the stack SHALL be left unchanged and stk_err SHALL set.
REQ-031 stk_full SHALL be high at occupancy SDEPTH; stk_empty SHALL be high at occupancy 0; the occupancy counter SHALL be log2(SDEPTH)+1 bits wide.
REQ-032 stk_err SHALL clear only on reset.
REQ-033 Out-of-range selects cannot occur, because NREG is a power of two.

Reset
REQ-034 Asserting rst_n low SHALL immediately clear all registers, all stack entries, occupancy and stk_err to 0.
REQ-035 After reset, stk_empty SHALL be 1, stk_full SHALL be 0 and link_addr SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard any pending write, push or pop.
REQ-037 The first update after reset SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-038 Macro REG_BYPASS_EN SHALL control write-to-read forwarding.
REQ-039 When REG_BYPASS_EN is defined, a read port whose select matches a register being written this cycle SHALL return the value being written (load value takes precedence), and src_zero SHALL be evaluated on the bypassed value.
REQ-040 When REG_BYPASS_EN is undefined, read ports SHALL return pre-edge register contents.

Verification
REQ-041 Reset, then ld_en with ld_sel=3 and ld_data=0x7F; next cycle op=incr with src=dst=3 and step=0 -> reg3 = 0x80; repeat with step=7 -> reg3 = 0x88.
REQ-042 reg5=0x03; op=decr with src=dst=5 and step=4 -> reg5 = 0xFE (wrap-around); op=mov with src=dst=5 -> reg5 = 0x00 and src_zero=1 during the mov cycle.
REQ-043 Five calls with npc=0x100..0x104 (SDEPTH=4) -> stk_full=1 after the 4th, 5th call dropped, stk_err=1, link_addr=0x103; four rets -> link_addr sequence 0x102, 0x101, 0x100, 0, then stk_empty=1.
REQ-044 Simultaneous call and ret with npc=0x2AA at occupancy 2 -> occupancy stays 2 and link_addr=0x2AA; on an empty stack -> occupancy 1.
REQ-045 Same-cycle ld_en to reg7=0x11 and mov to reg7 -> reg7=0x11; with REG_BYPASS_EN defined, rd_sel_a=7 reads 0x11 in that cycle, and without the macro it reads the old value.
REQ-046 Assert rst_n low between edges while a call is pending -> outputs go to reset values immediately, and no push occurs after release.
